// File: rtl/fifo_sync_flex.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_sync_flex
//  Purpose  : Single-clock FIFO with programmable almost-full/almost-empty
//             thresholds, live fill count, flush, and registered or FWFT read.
//  Revision : 1.0  - initial release
// ============================================================================
module fifo_sync_flex #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int PTR_WIDTH = $clog2(DEPTH),
    parameter int AF_LEVEL  = DEPTH - 2,
    parameter int AE_LEVEL  = 2,
    parameter int FWFT      = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 wr_en,
    input  logic [WIDTH-1:0]     wdata,
    input  logic                 rd_en,
    output logic [WIDTH-1:0]     rdata,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [PTR_WIDTH:0]   count,
    output logic                 wr_err,
    output logic                 rd_err
);

    localparam logic [PTR_WIDTH:0] c_ONE      = (PTR_WIDTH+1)'(1);
    localparam logic [PTR_WIDTH:0] c_AF_LEVEL = (PTR_WIDTH+1)'(AF_LEVEL);
    localparam logic [PTR_WIDTH:0] c_AE_LEVEL = (PTR_WIDTH+1)'(AE_LEVEL);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [PTR_WIDTH:0] r_wr_ptr;
    logic [PTR_WIDTH:0] r_rd_ptr;
    logic [PTR_WIDTH:0] r_count;
    logic               r_full;
    logic               r_empty;
    logic               r_almost_full;
    logic               r_almost_empty;
    logic               r_wr_err;
    logic               r_rd_err;
    logic [WIDTH-1:0]   r_rdata;

    logic               w_wr_acc;
    logic               w_rd_acc;
    logic [PTR_WIDTH:0] w_wr_ptr_nxt;
    logic [PTR_WIDTH:0] w_rd_ptr_nxt;
    logic [PTR_WIDTH:0] w_count_nxt;
    logic               w_full_nxt;
    logic               w_empty_nxt;
    logic [WIDTH-1:0]   w_head_word;
    logic [WIDTH-1:0]   w_head_nxt;

    // Acceptance looks only at registered flags, so no input reaches a flag
    // combinationally.
    assign w_wr_acc = wr_en & ~r_full;
    assign w_rd_acc = rd_en & ~r_empty;

    assign w_wr_ptr_nxt = w_wr_acc ? (r_wr_ptr + c_ONE) : r_wr_ptr;
    assign w_rd_ptr_nxt = w_rd_acc ? (r_rd_ptr + c_ONE) : r_rd_ptr;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_count_nxt = r_count + c_ONE;
            2'b01:   w_count_nxt = r_count - c_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    assign w_full_nxt  = (w_wr_ptr_nxt[PTR_WIDTH] != w_rd_ptr_nxt[PTR_WIDTH]) &&
                         (w_wr_ptr_nxt[PTR_WIDTH-1:0] == w_rd_ptr_nxt[PTR_WIDTH-1:0]);
    assign w_empty_nxt = (w_wr_ptr_nxt == w_rd_ptr_nxt);

    assign w_head_word = r_mem[r_rd_ptr[PTR_WIDTH-1:0]];

    // Next head word; the word being written this cycle may itself become the
    // head, so it is forwarded before it lands in memory.
    assign w_head_nxt = (w_wr_acc && (w_rd_ptr_nxt == r_wr_ptr)) ? wdata
                      : r_mem[w_rd_ptr_nxt[PTR_WIDTH-1:0]];

    always_ff @(posedge clk) begin
        if (!rst && !flush && w_wr_acc) begin
            r_mem[r_wr_ptr[PTR_WIDTH-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
            r_wr_err       <= 1'b0;
            r_rd_err       <= 1'b0;
        end else begin
            r_wr_ptr       <= w_wr_ptr_nxt;
            r_rd_ptr       <= w_rd_ptr_nxt;
            r_count        <= w_count_nxt;
            r_full         <= w_full_nxt;
            r_empty        <= w_empty_nxt;
            r_almost_full  <= (w_count_nxt >= c_AF_LEVEL);
            r_almost_empty <= (w_count_nxt <= c_AE_LEVEL);
            r_wr_err       <= wr_en & r_full;
            r_rd_err       <= rd_en & r_empty;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // rdata tracks the head; once drained it keeps the last word read.
            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    r_rdata <= '0;
                end else if (!w_empty_nxt) begin
                    r_rdata <= w_head_nxt;
                end
            end
        end else begin : g_std
            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    r_rdata <= '0;
                end else if (w_rd_acc) begin
                    r_rdata <= w_head_word;
                end
            end
        end
    endgenerate

    assign rdata        = r_rdata;
    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_almost_full;
    assign almost_empty = r_almost_empty;
    assign count        = r_count;
    assign wr_err       = r_wr_err;
    assign rd_err       = r_rd_err;

endmodule
`default_nettype wire

// File: tb/tb_fifo_sync_flex.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_sync_flex
//  Purpose  : Self-checking bench; registered and FWFT instances share one
//             stimulus stream and are compared against a queue model.
//  Revision : 1.0  - initial release
// ============================================================================
module tb_fifo_sync_flex;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int PW    = $clog2(DEPTH);
    localparam int AF    = DEPTH - 2;
    localparam int AE    = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic             wr_en = 1'b0;
    logic             rd_en = 1'b0;
    logic [WIDTH-1:0] wdata = '0;

    logic [WIDTH-1:0] s_rdata, f_rdata;
    logic             s_full, s_empty, s_af, s_ae, s_werr, s_rerr;
    logic             f_full, f_empty, f_af, f_ae, f_werr, f_rerr;
    logic [PW:0]      s_count, f_count;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] exp_rd_std  = '0;
    logic [WIDTH-1:0] exp_rd_fwft = '0;
    logic             exp_werr = 1'b0;
    logic             exp_rerr = 1'b0;

    always #5 clk = ~clk;

    fifo_sync_flex #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en),
        .rdata(s_rdata), .full(s_full), .empty(s_empty), .almost_full(s_af),
        .almost_empty(s_ae), .count(s_count), .wr_err(s_werr), .rd_err(s_rerr)
    );

    fifo_sync_flex #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en),
        .rdata(f_rdata), .full(f_full), .empty(f_empty), .almost_full(f_af),
        .almost_empty(f_ae), .count(f_count), .wr_err(f_werr), .rd_err(f_rerr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of the behavioural model, applied with the inputs sampled at the edge.
    task automatic model(input logic w, input logic r, input logic [WIDTH-1:0] d,
                         input logic f, input logic rs);
        int               n;
        logic             w_ok, r_ok;
        logic [WIDTH-1:0] popped;
        if (rs || f) begin
            q.delete();
            exp_rd_std  = '0;
            exp_rd_fwft = '0;
            exp_werr    = 1'b0;
            exp_rerr    = 1'b0;
            return;
        end
        n        = q.size();
        w_ok     = w && (n < DEPTH);
        r_ok     = r && (n > 0);
        exp_werr = w && !w_ok;
        exp_rerr = r && !r_ok;
        popped   = '0;
        if (r_ok) begin
            popped     = q.pop_front();
            exp_rd_std = popped;
        end
        if (w_ok) q.push_back(d);
        if (q.size() > 0) exp_rd_fwft = q[0];
        else if (r_ok)    exp_rd_fwft = popped;
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        chk("std_count",  32'(s_count), 32'(n));
        chk("std_full",   32'(s_full),  32'(n == DEPTH));
        chk("std_empty",  32'(s_empty), 32'(n == 0));
        chk("std_afull",  32'(s_af),    32'(n >= AF));
        chk("std_aempty", 32'(s_ae),    32'(n <= AE));
        chk("std_wr_err", 32'(s_werr),  32'(exp_werr));
        chk("std_rd_err", 32'(s_rerr),  32'(exp_rerr));
        chk("std_rdata",  32'(s_rdata), 32'(exp_rd_std));
        chk("fwft_count", 32'(f_count), 32'(n));
        chk("fwft_empty", 32'(f_empty), 32'(n == 0));
        chk("fwft_full",  32'(f_full),  32'(n == DEPTH));
        chk("fwft_afull", 32'(f_af),    32'(n >= AF));
        chk("fwft_aempty",32'(f_ae),    32'(n <= AE));
        chk("fwft_wr_err",32'(f_werr),  32'(exp_werr));
        chk("fwft_rd_err",32'(f_rerr),  32'(exp_rerr));
        chk("fwft_rdata", 32'(f_rdata), 32'(exp_rd_fwft));
    endtask

    task automatic step(input logic w, input logic r, input logic [WIDTH-1:0] d,
                        input logic f, input logic rs);
        wr_en = w; rd_en = r; wdata = d; flush = f; rst = rs;
        @(posedge clk);
        model(w, r, d, f, rs);
        #1;
        check_all();
    endtask

    initial begin
        // Reset
        step(0, 0, 8'h00, 0, 1);
        step(0, 0, 8'h00, 0, 1);
        step(0, 0, 8'h00, 0, 0);
        chk("reset_count", 32'(s_count), 32'd0);
        chk("reset_empty", 32'(s_empty), 32'd1);

        // Fill with 0x01..0x10, then one rejected write
        for (int i = 1; i <= DEPTH; i++) step(1, 0, 8'(i), 0, 0);
        chk("fill_full",  32'(s_full),  32'd1);
        chk("fill_count", 32'(s_count), 32'd16);
        step(1, 0, 8'h11, 0, 0);
        chk("ovf_wr_err", 32'(s_werr),  32'd1);
        step(0, 0, 8'h00, 0, 0);
        chk("ovf_pulse_end", 32'(s_werr), 32'd0);

        // Drain in order, then one rejected read
        for (int i = 1; i <= DEPTH; i++) begin
            step(0, 1, 8'h00, 0, 0);
            chk("drain_rdata", 32'(s_rdata), 32'(i));
        end
        chk("drain_empty", 32'(s_empty), 32'd1);
        step(0, 1, 8'h00, 0, 0);
        chk("udf_rd_err", 32'(s_rerr),  32'd1);
        chk("udf_hold",   32'(s_rdata), 32'h10);

        // Steady state at count 8 across a pointer wrap
        for (int i = 0; i < 8; i++) step(1, 0, 8'($urandom), 0, 0);
        for (int i = 0; i < 40; i++) begin
            step(1, 1, 8'($urandom), 0, 0);
            chk("steady_count", 32'(s_count), 32'd8);
        end

        // Simultaneous access when full, then when empty
        for (int i = 0; i < 8; i++) step(1, 0, 8'($urandom), 0, 0);
        step(1, 1, 8'hEE, 0, 0);
        chk("full_both_count", 32'(s_count), 32'd15);
        chk("full_both_werr",  32'(s_werr),  32'd1);
        for (int i = 0; i < 15; i++) step(0, 1, 8'h00, 0, 0);
        step(1, 1, 8'h3C, 0, 0);
        chk("empty_both_count", 32'(s_count), 32'd1);
        chk("empty_both_rerr",  32'(s_rerr),  32'd1);
        chk("empty_both_fwft",  32'(f_rdata), 32'h3C);

        // FWFT first-word latency
        step(0, 0, 8'h00, 1, 0);
        step(1, 0, 8'hA5, 0, 0);
        chk("fwft_first_word", 32'(f_rdata), 32'hA5);
        chk("fwft_not_empty",  32'(f_empty), 32'd0);
        step(0, 1, 8'h00, 0, 0);
        chk("fwft_drained", 32'(f_empty), 32'd1);

        // Flush and reset while writing
        for (int i = 0; i < 5; i++) step(1, 0, 8'(8'h40 + i), 0, 0);
        step(1, 0, 8'h99, 1, 0);
        chk("flush_count", 32'(s_count), 32'd0);
        step(0, 1, 8'h00, 0, 0);
        chk("flush_no_store", 32'(s_rerr), 32'd1);
        for (int i = 0; i < 5; i++) step(1, 0, 8'(8'h50 + i), 0, 0);
        step(1, 0, 8'h77, 0, 1);
        step(1, 1, 8'h61, 0, 0);
        chk("rst_then_write", 32'(s_count), 32'd1);

        // Random traffic with occasional flush/reset
        for (int i = 0; i < 400; i++) begin
            int wp, rp;
            wp = (i / 100) % 2 == 0 ? 70 : 35;
            rp = 100 - wp;
            step(($urandom_range(99) < wp), ($urandom_range(99) < rp), 8'($urandom),
                 ($urandom_range(39) == 0), ($urandom_range(149) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
